alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand and result width; legal values are 32 and 64.
REQ-002 Parameter EN_M, default 1, SHALL enable the multiply/divide ops; when 0, Funct7=0000001 decodes as illegal.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 flush  in  1  synchronous abort of any in-flight or held operation.
REQ-006 in_valid / in_ready  in / out  1 / 1  request handshake.
REQ-007 alu_op  in  3  class: 000 R, 010 I, 001 load/store, 011 jump, 100 branch, 101 LUI, 110 AUIPC.
REQ-008 funct7 / funct3  in  7 / 3  instruction fields.
REQ-009 src_a / src_b  in  XLEN / XLEN  operands.
REQ-010 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-011 result  out  XLEN  operation result.
REQ-012 br_taken  out  1  branch condition, meaningful only for alu_op=100.
REQ-013 illegal  out  1  undecodable request; in that case result SHALL be 0.

Function
REQ-014 Decode SHALL yield a 5-bit op; bit4=0 codes are AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, BEQ 1000, BNE 1001, SLT/BLT 1010, BGE 1011, SLTU/BLTU 1100, BGEU 1101, AUIPC-add 1110.
REQ-015 alu_op 001, 011 and 101 SHALL decode to ADD; alu_op 110 SHALL decode to 1110.
REQ-016 alu_op=000 with funct7=0000001 and EN_M=1 SHALL decode to 1_0_funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-017 Shift amount SHALL be src_b[$clog2(XLEN)-1:0].
REQ-018 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-019 A request SHALL be accepted on the cycle in_valid && in_ready.
REQ-020 Non-M ops SHALL present out_valid and result on the cycle after acceptance (latency 1).
REQ-021 FSM states SHALL be IDLE, MUL and DIV; an accepted M op SHALL move the FSM from IDLE to MUL or DIV.
REQ-022 MUL SHALL be radix-2 shift-add over a 2*XLEN product, taking exactly XLEN cycles, then returning to IDLE with out_valid asserted.
REQ-023 Signed MUL variants SHALL use operand magnitudes and negate the product at completion.
REQ-024 MUL SHALL return the low half of the product; MULH, MULHSU and MULHU SHALL return the high half.
REQ-025 DIV SHALL be restoring division over signed magnitudes, taking exactly XLEN cycles; the quotient sign is a^b and the remainder takes the sign of the dividend.
REQ-026 A divisor of 0 SHALL complete with latency 1: DIV/DIVU give all-ones, REM/REMU give src_a.
REQ-027 Signed overflow (src_a = most-negative, src_b = -1) SHALL complete with latency 1: DIV gives most-negative, REM gives 0.
REQ-028 out_valid, result, br_taken and illegal SHALL hold stable until out_ready is sampled high.
REQ-029 A new result MAY load on the same cycle the previous result is consumed (back-to-back latency-1 throughput).
REQ-030 flush SHALL force IDLE, clear out_valid and the counter, and override a simultaneous in_valid (nothing is accepted).
REQ-031 The iteration counter SHALL be $clog2(XLEN)+1 bits and SHALL never wrap during an operation.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE, out_valid=0, result=0, br_taken=0, illegal=0 and counter=0.
REQ-033 Deasserting reset mid-operation SHALL discard the operation; in_ready SHALL be 1 on the first clock after deassertion.

Structure
REQ-034 Package alu_pkg SHALL hold the alu_op class constants, the 5-bit op enum and the FSM state enum.
REQ-035 The combinational decode SHALL live in sub-module alu_op_decode (inputs alu_op, funct7, funct3, EN_M; outputs op, illegal).
REQ-036 The MUL and DIV datapaths SHALL share one 2*XLEN shift register and one XLEN-bit adder/subtractor.

Verification
REQ-037 Bench SHALL check: R-type funct7=0100000, funct3=000, a=5, b=7 -> result 0xFFFFFFFE, one cycle after acceptance.
REQ-038 Bench SHALL check: branch funct3=101, a=-1, b=0 -> br_taken=0; BLTU with the same operands -> br_taken=0; BLTU with a=0, b=-1 -> br_taken=1.
REQ-039 Bench SHALL check: MULH a=0x80000000, b=0x80000000 -> result 0x40000000 after 32 cycles, with in_ready low throughout.
REQ-040 Bench SHALL check: DIV a=0x80000000, b=-1 -> 0x80000000 at latency 1; REMU a=9, b=0 -> 9; DIV a=-7, b=2 -> -3; REM a=-7, b=2 -> -1.
REQ-041 Bench SHALL check: out_ready held low for 5 cycles -> result stable and in_ready low; release -> the next op is accepted that same cycle.
REQ-042 Bench SHALL check: flush, then rst_n pulsed low, at cycle 10 of a DIVU -> IDLE, out_valid=0, no stale result; a following ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU execution unit: request classes, decoded op codes
// and the multi-cycle sequencer states.
package alu_pkg;

    localparam logic [2:0] CLS_R      = 3'b000;
    localparam logic [2:0] CLS_LS     = 3'b001;
    localparam logic [2:0] CLS_I      = 3'b010;
    localparam logic [2:0] CLS_JUMP   = 3'b011;
    localparam logic [2:0] CLS_BRANCH = 3'b100;
    localparam logic [2:0] CLS_LUI    = 3'b101;
    localparam logic [2:0] CLS_AUIPC  = 3'b110;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_XOR    = 5'b00011,
        OP_SLL    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_SUB    = 5'b00110,
        OP_SRA    = 5'b00111,
        OP_BEQ    = 5'b01000,
        OP_BNE    = 5'b01001,
        OP_SLT    = 5'b01010,
        OP_BGE    = 5'b01011,
        OP_SLTU   = 5'b01100,
        OP_BGEU   = 5'b01101,
        OP_AUIPC  = 5'b01110,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_opc_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } alu_state_e;

    // funct3 mapping shared by register and immediate arithmetic
    function automatic alu_opc_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_unit_decode.sv
// Combinational instruction decode: request class + funct fields to a 5-bit op.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [2:0] alu_op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output alu_opc_e   op,
    output logic       illegal
);

    always_comb begin
        op      = OP_ADD;
        illegal = 1'b0;
        case (alu_op)
            CLS_R: begin
                if (funct7 == F7_BASE)                         op = base_op(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000) op = OP_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101) op = OP_SRA;
                else if (funct7 == F7_MULDIV && EN_M)          op = alu_opc_e'({2'b10, funct3});
                else                                           illegal = 1'b1;
            end
            CLS_I: begin
                // funct7 only qualifies the immediate shifts
                if (funct3 == 3'b001 && funct7 != F7_BASE)      illegal = 1'b1;
                else if (funct3 == 3'b101 && funct7 == F7_ALT)  op = OP_SRA;
                else if (funct3 == 3'b101 && funct7 != F7_BASE) illegal = 1'b1;
                else                                            op = base_op(funct3);
            end
            CLS_LS, CLS_JUMP, CLS_LUI: op = OP_ADD;
            CLS_AUIPC:                 op = OP_AUIPC;
            CLS_BRANCH: begin
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_SLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_SLTU;
                    3'b111:  op = OP_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle integer ops plus iterative multiply/divide
// sharing one double-width shift register and one adder.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            br_taken,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    alu_opc_e   dec_op;
    logic       dec_illegal;
    alu_state_e state_q, state_d;
    alu_opc_e   op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] sr_q, sr_d;
    logic [XLEN-1:0]   opnd_q, opnd_d, result_q, result_d;
    logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic out_valid_q, out_valid_d, br_taken_q, br_taken_d, illegal_q, illegal_d;

    logic accept, last_iter, start_mul, start_div;
    logic lt_s, lt_u, cmp, is_cmp, is_div, is_rem, div_zero, div_ovf, a_neg, b_neg;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res, a_mag, b_mag, add_x, add_y, quo, rem, iter_res;
    logic [XLEN:0]     add_sum;
    logic              add_cin;
    logic [2*XLEN-1:0] sr_step, prod;

    alu_op_decode #(.EN_M(EN_M)) u_decode (
        .alu_op  (alu_op),
        .funct7  (funct7),
        .funct3  (funct3),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    // Single-cycle result, including the divide corner cases that bypass iteration
    always_comb begin
        shamt    = src_b[SHW-1:0];
        lt_s     = $signed(src_a) < $signed(src_b);
        lt_u     = src_a < src_b;
        cmp      = 1'b0;
        alu_res  = '0;
        case (dec_op)
            OP_AND:           alu_res = src_a & src_b;
            OP_OR:            alu_res = src_a | src_b;
            OP_XOR:           alu_res = src_a ^ src_b;
            OP_ADD, OP_AUIPC: alu_res = src_a + src_b;
            OP_SUB:           alu_res = src_a - src_b;
            OP_SLL:           alu_res = src_a << shamt;
            OP_SRL:           alu_res = src_a >> shamt;
            OP_SRA:           alu_res = $unsigned($signed(src_a) >>> shamt);
            OP_BEQ:           cmp = (src_a == src_b);
            OP_BNE:           cmp = (src_a != src_b);
            OP_SLT:           cmp = lt_s;
            OP_BGE:           cmp = !lt_s;
            OP_SLTU:          cmp = lt_u;
            OP_BGEU:          cmp = !lt_u;
            default:          alu_res = '0;
        endcase
        is_cmp = (dec_op[4:3] == 2'b01) && (dec_op != OP_AUIPC);
        if (is_cmp) alu_res = {{(XLEN-1){1'b0}}, cmp};

        is_div   = dec_op[4] && dec_op[2];
        is_rem   = is_div && dec_op[1];
        div_zero = is_div && (src_b == '0);
        div_ovf  = is_div && !dec_op[0] && (src_a == MIN_NEG) && (src_b == '1);
        if (div_zero)     alu_res = is_rem ? src_a : '1;
        else if (div_ovf) alu_res = is_rem ? '0 : MIN_NEG;

        start_mul = !dec_illegal && dec_op[4] && !dec_op[2];
        start_div = !dec_illegal && is_div && !div_zero && !div_ovf;

        a_neg = src_a[XLEN-1] && (dec_op == OP_MULH || dec_op == OP_MULHSU ||
                                  dec_op == OP_DIV  || dec_op == OP_REM);
        b_neg = src_b[XLEN-1] && (dec_op == OP_MULH || dec_op == OP_DIV || dec_op == OP_REM);
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
    end

    // One iteration step: shift-add for MUL, shift-subtract-restore for DIV
    always_comb begin
        if (state_q == ST_DIV) begin
            add_x   = sr_q[2*XLEN-2:XLEN-1];
            add_y   = ~opnd_q;
            add_cin = 1'b1;
        end else begin
            add_x   = sr_q[2*XLEN-1:XLEN];
            add_y   = sr_q[0] ? opnd_q : '0;
            add_cin = 1'b0;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{XLEN{1'b0}}, add_cin};
        if (state_q == ST_DIV)
            sr_step = (sr_q[2*XLEN-1] || add_sum[XLEN]) ?
                      {add_sum[XLEN-1:0], sr_q[XLEN-2:0], 1'b1} : {sr_q[2*XLEN-2:0], 1'b0};
        else
            sr_step = {add_sum, sr_q[XLEN-1:1]};

        prod = neg_quo_q ? -sr_step : sr_step;
        quo  = neg_quo_q ? -sr_step[XLEN-1:0] : sr_step[XLEN-1:0];
        rem  = neg_rem_q ? -sr_step[2*XLEN-1:XLEN] : sr_step[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                      iter_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: iter_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             iter_res = quo;
            default:                     iter_res = rem;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        last_iter = (state_q != ST_IDLE) && (cnt_q == CW'(1));
        accept    = in_valid && in_ready && !flush;
        out_valid = out_valid_q;
        result    = result_q;
        br_taken  = br_taken_q;
        illegal   = illegal_q;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && start_mul)      state_d = ST_MUL;
                    else if (accept && start_div) state_d = ST_DIV;
                end
                ST_MUL, ST_DIV: if (last_iter) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        br_taken_d  = br_taken_q;
        illegal_d   = illegal_q;
        sr_d        = sr_q;
        opnd_d      = opnd_q;
        op_d        = op_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        cnt_d       = cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
            result_d    = '0;
            br_taken_d  = 1'b0;
            illegal_d   = 1'b0;
            cnt_d       = '0;
        end else if (accept) begin
            if (start_mul || start_div) begin
                out_valid_d = 1'b0;
                cnt_d       = CW'(XLEN);
                op_d        = dec_op;
                neg_quo_d   = a_neg ^ b_neg;
                neg_rem_d   = a_neg;
                opnd_d      = start_mul ? a_mag : b_mag;
                sr_d        = {{XLEN{1'b0}}, start_mul ? b_mag : a_mag};
            end else begin
                out_valid_d = 1'b1;
                result_d    = dec_illegal ? '0 : alu_res;
                br_taken_d  = !dec_illegal && cmp;
                illegal_d   = dec_illegal;
            end
        end else begin
            if (out_valid_q && out_ready) out_valid_d = 1'b0;
            if (state_q != ST_IDLE) begin
                sr_d  = sr_step;
                cnt_d = cnt_q - CW'(1);
                if (last_iter) begin
                    out_valid_d = 1'b1;
                    result_d    = iter_res;
                    br_taken_d  = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_AND;
            cnt_q       <= '0;
            sr_q        <= '0;
            opnd_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_taken_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            opnd_q      <= opnd_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            br_taken_q  <= br_taken_d;
            illegal_q   <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN=32, EN_M=1).
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, br_taken, illegal;
    logic [2:0]  alu_op = 3'b000, funct3 = 3'b000;
    logic [6:0]  funct7 = 7'b0;
    logic [31:0] src_a = '0, src_b = '0, result;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    alu_exec_unit #(.XLEN(32), .EN_M(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct7    (funct7),
        .funct3    (funct3),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .br_taken  (br_taken),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Present a request at the falling edge; return 1 time unit after the accepting edge.
    task automatic drive(input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_op = op; funct7 = f7; funct3 = f3; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output logic ready_seen);
        cyc = 0;
        ready_seen = in_ready;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
            if (!out_valid && in_ready) ready_seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || br_taken !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b result=%h br=%b ill=%b, want 0/0/0/0",
                     out_valid, result, br_taken, illegal);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_sub;
        drive(CLS_R, F7_ALT, 3'b000, 32'd5, 32'd7);
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL sub_latency1: got valid=%b result=%h, want 1/fffffffe", out_valid, result);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_consumed: got out_valid=%b, want 0", out_valid);
        end
    endtask

    // Requests issued on consecutive cycles; each result must land one cycle later.
    task automatic test_back_to_back;
        vec_t v[9];
        v[0] = '{CLS_R,     F7_BASE, 3'b000, 32'd3,         32'd4,         32'd7,         1'b0};
        v[1] = '{CLS_I,     F7_BASE, 3'b001, 32'd1,         32'h24,        32'h10,        1'b0};
        v[2] = '{CLS_R,     F7_ALT,  3'b101, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0};
        v[3] = '{CLS_I,     F7_BASE, 3'b011, 32'd1,         32'd2,         32'd1,         1'b0};
        v[4] = '{CLS_R,     F7_BASE, 3'b100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0};
        v[5] = '{CLS_LUI,   F7_BASE, 3'b000, 32'd0,         32'h1234_5000, 32'h1234_5000, 1'b0};
        v[6] = '{CLS_AUIPC, F7_BASE, 3'b000, 32'h1000,      32'h2000,      32'h3000,      1'b0};
        v[7] = '{CLS_R,     F7_ALT,  3'b001, 32'd9,         32'd9,         32'd0,         1'b1};
        v[8] = '{3'b111,    F7_BASE, 3'b000, 32'd9,         32'd9,         32'd0,         1'b1};
        for (int i = 0; i < 9; i++) begin
            drive(v[i].op, v[i].f7, v[i].f3, v[i].a, v[i].b);
            n_checks++;
            if (out_valid !== 1'b1 || result !== v[i].exp || illegal !== v[i].ill) begin
                n_fail++;
                $display("FAIL vec%0d: got valid=%b result=%h ill=%b, want 1/%h/%b",
                         i, out_valid, result, illegal, v[i].exp, v[i].ill);
            end
        end
    endtask

    task automatic test_branch;
        vec_t v[4];
        v[0] = '{CLS_BRANCH, F7_BASE, 3'b101, 32'hFFFF_FFFF, 32'd0,         32'd0, 1'b0};
        v[1] = '{CLS_BRANCH, F7_BASE, 3'b110, 32'hFFFF_FFFF, 32'd0,         32'd0, 1'b0};
        v[2] = '{CLS_BRANCH, F7_BASE, 3'b110, 32'd0,         32'hFFFF_FFFF, 32'd1, 1'b0};
        v[3] = '{CLS_BRANCH, F7_BASE, 3'b000, 32'd42,        32'd42,        32'd1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(v[i].op, v[i].f7, v[i].f3, v[i].a, v[i].b);
            n_checks++;
            if (out_valid !== 1'b1 || br_taken !== v[i].exp[0]) begin
                n_fail++;
                $display("FAIL branch%0d: got valid=%b br_taken=%b, want 1/%b",
                         i, out_valid, br_taken, v[i].exp[0]);
            end
        end
    endtask

    task automatic test_mul;
        int   cyc;
        logic rdy;
        drive(CLS_R, F7_MULDIV, 3'b001, 32'h8000_0000, 32'h8000_0000);
        wait_done(cyc, rdy);
        n_checks++;
        if (cyc != 32 || result !== 32'h4000_0000 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL mulh: got cycles=%0d result=%h ready_seen=%b, want 32/40000000/0",
                     cyc, result, rdy);
        end
        drive(CLS_R, F7_MULDIV, 3'b000, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc, rdy);
        n_checks++;
        if (cyc != 32 || result !== 32'hFFFF_FFF1) begin
            n_fail++;
            $display("FAIL mul_low: got cycles=%0d result=%h, want 32/fffffff1", cyc, result);
        end
        drive(CLS_R, F7_MULDIV, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, rdy);
        n_checks++;
        if (result !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL mulhu: got result=%h, want fffffffe", result);
        end
    endtask

    task automatic test_div;
        int   cyc;
        logic rdy;
        drive(CLS_R, F7_MULDIV, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_overflow: got valid=%b result=%h, want 1/80000000", out_valid, result);
        end
        drive(CLS_R, F7_MULDIV, 3'b111, 32'd9, 32'd0);
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'd9) begin
            n_fail++;
            $display("FAIL remu_by_zero: got valid=%b result=%h, want 1/00000009", out_valid, result);
        end
        drive(CLS_R, F7_MULDIV, 3'b101, 32'd5, 32'd0);
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL divu_by_zero: got valid=%b result=%h, want 1/ffffffff", out_valid, result);
        end
        drive(CLS_R, F7_MULDIV, 3'b100, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, rdy);
        n_checks++;
        if (cyc != 32 || result !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_neg: got cycles=%0d result=%h, want 32/fffffffd", cyc, result);
        end
        drive(CLS_R, F7_MULDIV, 3'b110, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, rdy);
        n_checks++;
        if (result !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL rem_neg: got result=%h, want ffffffff", result);
        end
        drive(CLS_R, F7_MULDIV, 3'b101, 32'd100, 32'd7);
        wait_done(cyc, rdy);
        n_checks++;
        if (result !== 32'd14) begin
            n_fail++;
            $display("FAIL divu: got result=%h, want 0000000e", result);
        end
    endtask

    task automatic test_backpressure;
        logic unstable, ready_seen;
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(CLS_R, F7_BASE, 3'b000, 32'd10, 32'd20);
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'd30) begin
            n_fail++;
            $display("FAIL bp_first: got valid=%b result=%h, want 1/0000001e", out_valid, result);
        end
        unstable = 1'b0;
        ready_seen = 1'b0;
        @(negedge clk);
        alu_op = CLS_R; funct7 = F7_BASE; funct3 = 3'b100; src_a = 32'hFF; src_b = 32'h0F;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || result !== 32'd30) unstable = 1'b1;
            if (in_ready !== 1'b0) ready_seen = 1'b1;
        end
        n_checks++;
        if (unstable !== 1'b0 || ready_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got unstable=%b ready_seen=%b, want 0/0", unstable, ready_seen);
        end
        @(negedge clk) out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got in_ready=%b, want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'hF0) begin
            n_fail++;
            $display("FAIL bp_next: got valid=%b result=%h, want 1/000000f0", out_valid, result);
        end
    endtask

    task automatic test_flush_reset;
        logic stale;
        drive(CLS_R, F7_MULDIV, 3'b101, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_div: got valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        alu_op = CLS_R; funct7 = F7_BASE; funct3 = 3'b000; src_a = 32'd1; src_b = 32'd1;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_overrides_valid: got out_valid=%b, want 0", out_valid);
        end
        drive(CLS_R, F7_MULDIV, 3'b101, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_div: got valid=%b result=%h, want 0/00000000", out_valid, result);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got in_ready=%b, want 1", in_ready);
        end
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_checks++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL no_stale_result: got stale=%b, want 0", stale);
        end
        drive(CLS_R, F7_BASE, 3'b000, 32'd2, 32'd3);
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'd5) begin
            n_fail++;
            $display("FAIL add_after_reset: got valid=%b result=%h, want 1/00000005", out_valid, result);
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_back_to_back();
        test_branch();
        test_mul();
        test_div();
        test_backpressure();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
